mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 131 +++++++++++++
 tb/tb_mult_div_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle HI/LO multiply/divide unit for the E stage.
//   MULT_CYCLES / DIV_CYCLES : busy duration of mult(u) / div(u), 1..15
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low
//   start  : valid MDU instruction in E
//   md_op  : 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6..7 no-op
//   src_a  : forwarded rs operand
//   src_b  : forwarded rt operand
//   busy   : mult/div in flight
//   hi, lo : architectural HI / LO registers
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, next_state;
  logic [3:0]  cnt;
  logic [31:0] pend_hi, pend_lo;
  logic        pend_valid;

  // Result datapath (purely combinational, only its commit is timed)
  logic signed [63:0] sa, sb;
  logic [63:0]        prod_s, prod_u;
  logic signed [31:0] s_num, s_den, s_quo, s_rem;
  logic [31:0]        u_den, u_quo, u_rem;
  logic               div_zero, div_ovf;

  always_comb begin
    sa     = {{32{src_a[31]}}, src_a};
    sb     = {{32{src_b[31]}}, src_b};
    prod_s = sa * sb;
    prod_u = {32'b0, src_a} * {32'b0, src_b};

    div_zero = (src_b == '0);
    // 0x80000000 / -1 overflows 32-bit signed division; pin it explicitly
    div_ovf  = (src_a == 32'h8000_0000) && (src_b == '1);
    s_num    = $signed(src_a);
    s_den    = (div_zero || div_ovf) ? 32'sd1 : $signed(src_b);
    s_quo    = s_num / s_den;
    s_rem    = s_num % s_den;
    u_den    = div_zero ? 32'd1 : src_b;
    u_quo    = src_a / u_den;
    u_rem    = src_a % u_den;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start && (md_op < 3'd4)) next_state = RUN;
      RUN:  if (cnt == '0)               next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state == RUN);
  end

  // Counter, pending result and HI/LO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      pend_hi    <= '0;
      pend_lo    <= '0;
      pend_valid <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        case (md_op)
          3'd0: begin
            {pend_hi, pend_lo} <= prod_s;
            pend_valid         <= 1'b1;
            cnt                <= 4'(MULT_CYCLES - 1);
          end
          3'd1: begin
            {pend_hi, pend_lo} <= prod_u;
            pend_valid         <= 1'b1;
            cnt                <= 4'(MULT_CYCLES - 1);
          end
          3'd2: begin
            pend_hi    <= div_ovf ? 32'h0 : s_rem;
            pend_lo    <= div_ovf ? 32'h8000_0000 : s_quo;
            pend_valid <= !div_zero;
            cnt        <= 4'(DIV_CYCLES - 1);
          end
          3'd3: begin
            pend_hi    <= u_rem;
            pend_lo    <= u_quo;
            pend_valid <= !div_zero;
            cnt        <= 4'(DIV_CYCLES - 1);
          end
          3'd4:    hi <= src_a;
          3'd5:    lo <= src_a;
          default: ;
        endcase
      end
    end else begin
      if (cnt == '0) begin
        // Divide-by-zero leaves HI/LO untouched
        if (pend_valid) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed bench for mult_div_unit with hand-computed expectations.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a, src_b;
  logic        busy;
  logic [31:0] hi, lo;

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned fails  = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .src_a(src_a), .src_b(src_b), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue a mult/div at the next edge (k), then check busy and the held
  // HI/LO for n-1 cycles and the committed values at edge k+n.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input int unsigned n,
                        input logic [31:0] old_hi, input logic [31:0] old_lo,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    start = 1'b1; md_op = op; src_a = a; src_b = b;
    tick();
    start = 1'b0; src_a = '0; src_b = '0;
    chk({tag, "_busy_k"}, 32'(busy), 32'd1);
    for (int unsigned i = 1; i < n; i++) begin
      tick();
      chk({tag, "_busy_mid"}, 32'(busy), 32'd1);
      chk({tag, "_hi_hold"}, hi, old_hi);
      chk({tag, "_lo_hold"}, lo, old_lo);
    end
    tick();
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; md_op = '0; src_a = '0; src_b = '0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    tick();
    tick();
    reset = 1'b1;

    // First edge after release accepts the mult
    run_op("mult", 3'd0, 32'hFFFF_FFFF, 32'd2, 5, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
           32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'h0000_0001, 32'hFFFF_FFFE,
           32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", 3'd3, 32'd7, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1, 32'd3);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd1, 32'd3,
           32'h0, 32'h8000_0000);

    // mthi / mtlo commit at once, no busy
    start = 1'b1; md_op = 3'd4; src_a = 32'h1234_5678;
    tick();
    chk("mthi_busy", 32'(busy), 32'd0);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_lo", lo, 32'h8000_0000);
    md_op = 3'd5; src_a = 32'h9ABC_DEF0;
    tick();
    start = 1'b0;
    chk("mtlo_busy", 32'(busy), 32'd0);
    chk("mtlo_hi", hi, 32'h1234_5678);
    chk("mtlo_lo", lo, 32'h9ABC_DEF0);

    run_op("divu0", 3'd3, 32'd55, 32'd0, 10, 32'h1234_5678, 32'h9ABC_DEF0,
           32'h1234_5678, 32'h9ABC_DEF0);

    // No-op codes ignored
    start = 1'b1; md_op = 3'd6; src_a = 32'hAAAA_AAAA; src_b = 32'd3;
    tick();
    md_op = 3'd7;
    tick();
    start = 1'b0;
    chk("nop_busy", 32'(busy), 32'd0);
    chk("nop_hi", hi, 32'h1234_5678);
    chk("nop_lo", lo, 32'h9ABC_DEF0);

    // mult, then mtlo while busy at k+2: ignored
    start = 1'b1; md_op = 3'd0; src_a = 32'h0001_0001; src_b = 32'h0003_0000;
    tick();                                     // edge k
    start = 1'b0;
    tick();                                     // edge k+1
    start = 1'b1; md_op = 3'd5; src_a = 32'hDEAD_BEEF;
    tick();                                     // edge k+2
    start = 1'b0;
    chk("ign_busy", 32'(busy), 32'd1);
    chk("ign_lo_hold", lo, 32'h9ABC_DEF0);
    tick();                                     // k+3
    tick();                                     // k+4
    chk("ign_busy_k4", 32'(busy), 32'd1);
    tick();                                     // k+5
    chk("ign_busy_done", 32'(busy), 32'd0);
    chk("ign_hi", hi, 32'h0000_0003);
    chk("ign_lo", lo, 32'h0003_0000);

    // div, then reset pulse in cycle k+4
    start = 1'b1; md_op = 3'd2; src_a = 32'd100; src_b = 32'd7;
    tick();                                     // edge k
    start = 1'b0;
    for (int unsigned i = 1; i <= 4; i++) tick();
    chk("rmid_busy_pre", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_hi", hi, 32'h0);
    chk("rmid_lo", lo, 32'h0);
    #2;
    reset = 1'b1;
    for (int unsigned i = 5; i <= 15; i++) begin
      tick();
      chk("rpost_busy", 32'(busy), 32'd0);
      chk("rpost_hi", hi, 32'h0);
      chk("rpost_lo", lo, 32'h0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
